// File: rtl/dsp_feeder_pkg.sv
// Shared widths, result entry type and A-port sign extension for the DSP operand feeder.
package dsp_feeder_pkg;
  localparam int A_W     = 27;
  localparam int B_W     = 18;
  localparam int P_W     = 48;
  localparam int DSP_A_W = 30;

  // AREG=2 plus MREG=1; PREG=0 adds nothing
  localparam int DSP_LATENCY = 3;

  typedef struct packed {
    logic [47:0] p;
    logic        last;
  } result_t;

  function automatic logic [DSP_A_W-1:0] sext_a(input logic [A_W-1:0] a);
    return {{(DSP_A_W-A_W){a[A_W-1]}}, a};
  endfunction
endpackage

// File: rtl/dsp_result_fifo.sv
// Generic synchronous first-word-fall-through FIFO of result_t with occupancy count.
// Latency: a push is visible at the head the following cycle. Backpressure: none; the caller guarantees a free slot.
// Push and pop may coincide even when full, since the head is read before the slot is rewritten.
module dsp_result_fifo
  import dsp_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  result_t                push_dat,
  input  logic                   pop,
  output result_t                head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  result_t       mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          pop_ok;

  assign pop_ok   = pop & (count != '0);
  // Empty FIFO presents zeros so the outputs read 0 out of reset
  assign head_dat = (count != '0) ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end
endmodule

// File: rtl/dsp_operand_feeder.sv
// Feeds signed operand pairs to a registered DSP48E2 multiplier and collects P into a result FIFO.
// Latency: LATENCY+1 cycles input to out_valid (4 by default); 1 beat/cycle sustained.
// Backpressure: inputs are credit-gated on pipe+FIFO occupancy; DSP_FEEDER_ACCUM_EN sums beats up to in_last.
module dsp_operand_feeder
  import dsp_feeder_pkg::*;
#(
  parameter int LATENCY    = DSP_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [A_W-1:0]                in_a,
  input  logic [B_W-1:0]                in_b,
  input  logic                          in_last,
  output logic [DSP_A_W-1:0]            dsp_a,
  output logic [B_W-1:0]                dsp_b,
  input  logic [P_W-1:0]                dsp_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [P_W-1:0]                out_p,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   inflight
);
  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  CREDITS = CW'(FIFO_DEPTH);

  logic               fire;
  logic               pop;
  logic               push;
  logic               rel;
  logic               cap_vld;
  logic [LATENCY-1:0] vpipe;
  result_t            push_dat;
  result_t            head_dat;
  logic [CW-1:0]      fifo_cnt;

  assign in_ready  = inflight < CREDITS;
  assign fire      = in_valid & in_ready;
  // Idle cycles drive zeros so the slice sees no spurious operands
  assign dsp_a     = fire ? sext_a(in_a) : '0;
  assign dsp_b     = fire ? in_b : '0;
  assign cap_vld   = vpipe[LATENCY-1];
  assign out_valid = fifo_cnt != '0;
  assign pop       = out_valid & out_ready;
  assign out_p     = head_dat.p;
  assign out_last  = head_dat.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe    <= '0;
      inflight <= '0;
    end else begin
      vpipe[0] <= fire;
      for (int i = 1; i < LATENCY; i++) vpipe[i] <= vpipe[i-1];
      inflight <= inflight + CW'(fire) - CW'(pop) - CW'(rel);
    end
  end

`ifdef DSP_FEEDER_ACCUM_EN
  logic [LATENCY-1:0] lpipe;
  logic [P_W-1:0]     acc;
  logic [P_W-1:0]     sum;
  logic               acc_load;

  assign sum      = acc_load ? dsp_p : acc + dsp_p;
  assign push     = cap_vld & lpipe[LATENCY-1];
  // Non-last beats never occupy the FIFO, so their credit returns at capture
  assign rel      = cap_vld & ~lpipe[LATENCY-1];
  assign push_dat = '{p: sum, last: 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      lpipe    <= '0;
      acc      <= '0;
      acc_load <= 1'b1;
    end else begin
      lpipe[0] <= fire & in_last;
      for (int i = 1; i < LATENCY; i++) lpipe[i] <= lpipe[i-1];
      if (cap_vld) begin
        acc      <= sum;
        acc_load <= lpipe[LATENCY-1];
      end
    end
  end
`else
  logic unused_last;

  assign unused_last = in_last;
  assign push        = cap_vld;
  assign rel         = 1'b0;
  assign push_dat    = '{p: dsp_p, last: 1'b1};
`endif

  dsp_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_cnt)
  );
endmodule

// File: tb/tb_dsp_operand_feeder.sv
// Scoreboard bench for dsp_operand_feeder with a behavioural AREG2/BREG2/MREG1 DSP48E2 model attached.
module tb_dsp_operand_feeder;
  import dsp_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic        in_last = 1'b0;
  logic [29:0] dsp_a;
  logic [17:0] dsp_b;
  logic [47:0] dsp_p;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_p;
  logic        out_last;
  logic [2:0]  inflight;

  int      checks = 0;
  int      errors = 0;
  int      max_inf = 0;
  bit      rand_rdy = 1'b0;
  result_t exp_q[$];

  always #5 clk = ~clk;

  dsp_operand_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_p(dsp_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_last(out_last), .inflight(inflight)
  );

  // Slice model: two A/B register stages, one M stage, unregistered P
  logic [29:0]        a1, a2;
  logic [17:0]        b1, b2;
  logic signed [44:0] m;
  always @(posedge clk) begin
    a1 <= dsp_a;
    a2 <= a1;
    b1 <= dsp_b;
    b2 <= b1;
    m  <= $signed(a2[26:0]) * $signed(b2);
  end
  assign dsp_p = {{3{m[44]}}, m};

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got p=%h last=%b, no result expected", out_p, out_last);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        if (out_p !== e.p || out_last !== e.last) begin
          errors++;
          $display("FAIL result got p=%h last=%b expected p=%h last=%b", out_p, out_last, e.p, e.last);
        end
      end
    end
    if (int'(inflight) > max_inf) max_inf = int'(inflight);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [26:0] a, input logic [17:0] b, input bit last,
                      input bit push_exp, input logic [47:0] exp_p);
    int waited = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected 1 within 200 cycles");
    end else if (push_exp) begin
      exp_q.push_back('{p: exp_p, last: 1'b1});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string name);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check({name, "_early"}, 64'(out_valid), 64'(0));
    end
    @(negedge clk);
    check({name, "_at4"}, 64'(out_valid), 64'(1));
  endtask

  initial begin
    int                 acc_n;
    int                 stale;
    logic signed [26:0] ra;
    logic signed [17:0] rb;
    logic signed [47:0] rp;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_p",     64'(out_p),     64'(0));
    check("rst_out_last",  64'(out_last),  64'(0));
    check("rst_dsp_a",     64'(dsp_a),     64'(0));
    check("rst_dsp_b",     64'(dsp_b),     64'(0));
    check("rst_inflight",  64'(inflight),  64'(0));
    @(posedge clk);
    #1;

    send(27'd3, -18'sd5, 1'b1, 1'b1, 48'hFFFF_FFFF_FFF1);
    check_latency("single");
    wait_drain();

    send(27'h400_0000, 18'h2_0000, 1'b1, 1'b1, 48'h0000_0800_0000_0000);
    send(27'h3FF_FFFF, 18'h1_FFFF, 1'b1, 1'b1, 48'h0000_07FF_FBFE_0001);
    wait_drain();

    // Backpressure: only the credit budget may be accepted while the consumer stalls
    out_ready = 1'b0;
    acc_n     = 0;
    in_valid  = 1'b1;
    in_a      = 27'd100;
    in_b      = 18'd3;
    in_last   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) check("bp_ready_low_c4", 64'(in_ready), 64'(0));
      if (in_ready) begin
        exp_q.push_back('{p: 48'(300 + 3 * acc_n), last: 1'b1});
        acc_n++;
      end
      @(posedge clk);
      #1;
      in_a = 27'(100 + acc_n);
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc_n),    64'(4));
    check("bp_inflight", 64'(inflight), 64'(4));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_before_pop", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("bp_ready_after_pop", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    for (int n = acc_n; n < 10; n++) send(27'(100 + n), 18'd3, 1'b1, 1'b1, 48'(300 + 3 * n));
    wait_drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra = 27'($urandom);
      rb = 18'($urandom);
      rp = 48'(ra) * 48'(rb);
      send(ra, rb, 1'b1, 1'b1, rp);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    // Reset with three products still inside the slice: none may surface
    send(27'd11, 18'd2, 1'b1, 1'b0, 48'd0);
    send(27'd12, 18'd2, 1'b1, 1'b0, 48'd0);
    send(27'd13, 18'd2, 1'b1, 1'b0, 48'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_mid_stale_outputs", 64'(stale),    64'(0));
    check("rst_mid_inflight",      64'(inflight), 64'(0));
    @(posedge clk);
    #1;
    send(-27'sd7, 18'd6, 1'b1, 1'b1, 48'hFFFF_FFFF_FFD6);
    check_latency("after_rst");
    wait_drain();

`ifdef DSP_FEEDER_ACCUM_EN
    send(27'd2,     18'd1, 1'b0, 1'b0, 48'd0);
    send(27'd3,     18'd1, 1'b0, 1'b0, 48'd0);
    send(-27'sd1,   18'd1, 1'b1, 1'b1, 48'd4);
    wait_drain();
    send(27'd7,     18'd1, 1'b1, 1'b1, 48'd7);
    wait_drain();
`endif

    check("inflight_max",  64'(max_inf),      64'(4));
    check("queue_empty",   64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
